// File: rtl/sha_auth_ctrl_if.sv
// Host and sha256-wrapper signal bundle for the authentication controller.
// slave is the controller side, master the host/wrapper environment side.
interface sha_auth_ctrl_if;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        sha_rst_n;
  logic        sha_cs;
  logic        sha_we;
  logic        sha_wc;
  logic [2:0]  sha_addr;
  logic [31:0] sha_wdata;
  logic        sha_digest_valid;
  logic        busy;
  logic        auth_pass;
  logic        auth_fail;
  logic        locked;
  logic [3:0]  fail_count;

  modport slave (
    input  start, abort, in_valid, in_data, sha_digest_valid,
    output in_ready, sha_rst_n, sha_cs, sha_we, sha_wc, sha_addr, sha_wdata,
    output busy, auth_pass, auth_fail, locked, fail_count
  );

  modport master (
    output start, abort, in_valid, in_data, sha_digest_valid,
    input  in_ready, sha_rst_n, sha_cs, sha_we, sha_wc, sha_addr, sha_wdata,
    input  busy, auth_pass, auth_fail, locked, fail_count
  );
endinterface

// File: rtl/sha_auth_ctrl.sv
// Authentication sequencer: loads block and reference digest into a sha256 wrapper,
// fires the hash, waits for its match flag and tracks consecutive failures into lockout.
module sha_auth_ctrl #(
  parameter int unsigned HASH_WAIT = 80,
  parameter int unsigned MAX_FAIL  = 3
) (
  input logic            clk,
  input logic            reset,
  sha_auth_ctrl_if.slave bus
);

  localparam int unsigned     CntW      = (HASH_WAIT > 1) ? $clog2(HASH_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(HASH_WAIT - 1);
  localparam logic [3:0]      FailLimit = 4'(MAX_FAIL);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StClr     = 4'd1;
  localparam logic [3:0] StLoadBlk = 4'd2;
  localparam logic [3:0] StLoadDig = 4'd3;
  localparam logic [3:0] StHash    = 4'd4;
  localparam logic [3:0] StWait    = 4'd5;
  localparam logic [3:0] StPass    = 4'd6;
  localparam logic [3:0] StFail    = 4'd7;
  localparam logic [3:0] StLock    = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      fail_cnt_q, fail_cnt_d;
  logic            sha_rst_n_q;
  logic            load;
  logic            accept;
  logic [3:0]      fail_inc;

  assign load     = (state_q == StLoadBlk) || (state_q == StLoadDig);
  assign accept   = load & bus.in_valid;
  assign fail_inc = (fail_cnt_q == 4'hf) ? 4'hf : fail_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start) state_d = StClr;
      end
      StClr: begin
        state_d = bus.abort ? StIdle : StLoadBlk;
      end
      StLoadBlk, StLoadDig: begin
        if (accept) idx_d = idx_q + 3'd1;
        // An abort still lets a coincident word reach the wrapper; only the sequence stops.
        if (bus.abort) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (accept && (idx_q == 3'd7)) begin
          state_d = (state_q == StLoadBlk) ? StLoadDig : StHash;
        end
      end
      StHash: begin
        cnt_d   = '0;
        state_d = bus.abort ? StFail : StWait;
      end
      StWait: begin
        // Match flag beats a coincident timeout.
        if (bus.abort) begin
          state_d = StFail;
        end else if (bus.sha_digest_valid) begin
          state_d = StPass;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = StFail;
        end
      end
      StPass: begin
        fail_cnt_d = '0;
        state_d    = StIdle;
      end
      StFail: begin
        fail_cnt_d = fail_inc;
        state_d    = (fail_inc >= FailLimit) ? StLock : StIdle;
      end
      StLock: begin
        state_d = StLock;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      fail_cnt_q  <= '0;
      sha_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      // Registered from next state so the wrapper sees reset exactly during CLR.
      sha_rst_n_q <= (state_d != StClr);
    end
  end

  assign bus.in_ready   = load;
  assign bus.sha_we     = accept;
  assign bus.sha_wc     = (state_q == StLoadBlk);
  assign bus.sha_addr   = idx_q;
  assign bus.sha_wdata  = load ? bus.in_data : '0;
  assign bus.sha_cs     = (state_q == StHash);
  assign bus.sha_rst_n  = sha_rst_n_q;
  assign bus.busy       = (state_q != StIdle) && (state_q != StLock);
  assign bus.auth_pass  = (state_q == StPass);
  assign bus.auth_fail  = (state_q == StFail);
  assign bus.locked     = (state_q == StLock);
  assign bus.fail_count = fail_cnt_q;

endmodule

// File: tb/tb_sha_auth_ctrl.sv
// Randomized bench for sha_auth_ctrl with a sha256-wrapper stand-in and an
// attempt-level outcome model (pass/fail/abort, failure count, lockout, latencies).
module tb_sha_auth_ctrl;

  localparam int unsigned HashWait = 80;
  localparam int unsigned MaxFail  = 3;
  localparam logic [31:0] Key      = 32'hC3A5_5A3C;

  localparam int KGood      = 0;
  localparam int KBad       = 1;
  localparam int KAbortLoad = 2;
  localparam int KAbortWait = 3;
  localparam int KAbortClr  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sha_auth_ctrl_if bus ();

  sha_auth_ctrl #(
    .HASH_WAIT(HashWait),
    .MAX_FAIL (MaxFail)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in hash: digest word i must equal hash_word(block word i).
  function automatic logic [31:0] hash_word(input logic [31:0] w);
    return {w[15:0], w[31:16]} ^ Key;
  endfunction

  // Monitor and wrapper model.
  int          we_n, cs_n, pass_n, failp_n, rstlow_n, cs_cyc, pass_cyc, fail_cyc;
  logic [35:0] we_log[$];
  logic [31:0] wblk[8];
  logic [31:0] wdig[8];
  logic        flag  = 1'b0;
  logic        armed = 1'b0;
  int          wcnt  = 0;
  int          delay_cfg = 1;

  always @(negedge clk) begin
    if (!bus.sha_rst_n) begin
      flag  = 1'b0;
      armed = 1'b0;
      rstlow_n++;
    end else begin
      if (bus.sha_we) begin
        we_n++;
        we_log.push_back({bus.sha_wc, bus.sha_addr, bus.sha_wdata});
        if (bus.sha_wc) wblk[bus.sha_addr] = bus.sha_wdata;
        else            wdig[bus.sha_addr] = bus.sha_wdata;
      end
      if (bus.sha_cs) begin
        cs_n++;
        cs_cyc = cyc;
        wcnt   = 0;
        armed  = 1'b1;
        for (int i = 0; i < 8; i++) if (wdig[i] != hash_word(wblk[i])) armed = 1'b0;
      end else if (armed) begin
        wcnt++;
        if (wcnt >= delay_cfg) flag = 1'b1;
      end
    end
    if (bus.auth_pass) begin pass_n++;  pass_cyc = cyc; end
    if (bus.auth_fail) begin failp_n++; fail_cyc = cyc; end
    bus.sha_digest_valid = flag;
  end

  // Reference model state.
  int m_fail_cnt = 0;
  bit m_locked   = 1'b0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    we_n = 0; cs_n = 0; pass_n = 0; failp_n = 0; rstlow_n = 0;
    cs_cyc = 0; pass_cyc = 0; fail_cyc = 0;
    we_log.delete();
  endtask

  task automatic do_reset(input bit chk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    reset = 1'b1;
    #1;
    if (chk) begin
      check_eq("rst_sha_rst_n", bus.sha_rst_n, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_locked", bus.locked, 0);
      check_eq("rst_fail_count", bus.fail_count, 0);
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_bus", {bus.sha_we, bus.sha_wc, bus.sha_cs, bus.sha_addr}, 0);
      check_eq("rst_wdata", bus.sha_wdata, 0);
      check_eq("rst_pulses", {bus.auth_pass, bus.auth_fail}, 0);
    end
    bus.in_valid = 1'b0;
    m_fail_cnt = 0;
    m_locked   = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    if (chk) check_eq("rst_n_rise", bus.sha_rst_n, 1);
  endtask

  task automatic run_attempt(input int kind, input int k, input int delay,
                             input bit toggle, input bit av);
    logic [31:0] w[16];
    int          idx = 0;
    int          budget;
    int          exp_we, exp_diff;
    bit          v, v_prev = 1'b0, rdy, aborted = 1'b0, exp_pass = 1'b0, exp_fail = 1'b0;
    logic [2:0]  a;
    for (int i = 0; i < 8; i++) begin
      w[i]     = $urandom;
      w[i + 8] = hash_word(w[i]);
    end
    if (kind == KBad || kind == KAbortWait) begin
      int j = 8 + int'($urandom_range(0, 7));
      w[j] = w[j] ^ (32'd1 << $urandom_range(0, 31));
    end
    delay_cfg = delay;
    clear_mon();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (kind == KAbortClr) begin
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
    end else begin
      budget = 200;
      while (idx < 16 && !aborted && budget > 0) begin
        rdy = bus.in_ready;
        v   = toggle ? ~v_prev : ($urandom_range(0, 3) != 0);
        if (kind == KAbortLoad && idx == k && rdy) begin
          v         = av;
          bus.abort = 1'b1;
          aborted   = 1'b1;
        end
        v_prev       = v;
        bus.in_valid = v;
        bus.in_data  = w[idx];
        tick();
        if (rdy && v) idx++;
        budget--;
      end
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
      check_eq("load_budget", budget > 0, 1);
      if (kind == KAbortWait) begin
        if (k >= 0) repeat (k + 1) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
      end
    end
    budget = 300;
    while (bus.busy && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("idle_budget", budget > 0, 1);
    tick();

    exp_diff = 0;
    case (kind)
      KGood: begin
        if (delay <= int'(HashWait)) begin exp_pass = 1'b1; exp_diff = delay + 1; end
        else begin exp_fail = 1'b1; exp_diff = HashWait + 1; end
      end
      KBad:       begin exp_fail = 1'b1; exp_diff = HashWait + 1; end
      KAbortWait: begin exp_fail = 1'b1; exp_diff = k + 2; end
      default: ;
    endcase
    exp_we = (kind == KAbortClr) ? 0 : (kind == KAbortLoad) ? k + int'(av) : 16;
    if (exp_pass) m_fail_cnt = 0;
    if (exp_fail) begin
      m_fail_cnt = (m_fail_cnt >= 15) ? 15 : m_fail_cnt + 1;
      if (m_fail_cnt >= int'(MaxFail)) m_locked = 1'b1;
    end

    check_eq("we_count", we_n, exp_we);
    for (int i = 0; i < we_log.size() && i < exp_we; i++) begin
      a = i[2:0];
      check_eq("we_entry", we_log[i], {(i < 8), a, w[i]});
    end
    check_eq("cs_count", cs_n, (exp_pass || exp_fail) ? 1 : 0);
    check_eq("clr_cycles", rstlow_n, 1);
    check_eq("pass_pulses", pass_n, exp_pass);
    check_eq("fail_pulses", failp_n, exp_fail);
    if (exp_pass) check_eq("pass_latency", pass_cyc - cs_cyc, exp_diff);
    if (exp_fail) check_eq("fail_latency", fail_cyc - cs_cyc, exp_diff);
    check_eq("fail_count", bus.fail_count, m_fail_cnt);
    check_eq("locked", bus.locked, m_locked);
    check_eq("busy_after", bus.busy, 0);
  endtask

  task automatic locked_try();
    clear_mon();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("lock_busy", bus.busy, 0);
    repeat (3) tick();
    check_eq("lock_cs", cs_n, 0);
    check_eq("lock_locked", bus.locked, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, k, delay;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b1);

    run_attempt(KGood, 0, 64, 1'b0, 1'b0);           // nominal pass
    run_attempt(KBad, 0, 1, 1'b0, 1'b0);             // stale flag still high, must fail
    run_attempt(KGood, 0, HashWait, 1'b0, 1'b0);     // match on the timeout cycle
    run_attempt(KGood, 0, HashWait + 1, 1'b0, 1'b0); // one cycle too late
    run_attempt(KAbortLoad, 5, 1, 1'b1, 1'b0);       // toggled valid, abort at word 5
    run_attempt(KAbortClr, 0, 1, 1'b0, 1'b0);
    run_attempt(KAbortWait, -1, 1, 1'b0, 1'b0);      // abort during HASH
    run_attempt(KBad, 0, 1, 1'b1, 1'b0);             // third consecutive failure
    locked_try();
    do_reset(1'b1);
    run_attempt(KGood, 0, 10, 1'b0, 1'b0);

    // Reset in the middle of a load.
    bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) tick();
    do_reset(1'b1);

    for (int it = 0; it < 30; it++) begin
      if (m_locked) begin
        locked_try();
        do_reset(1'b0);
      end
      kind  = int'($urandom_range(0, 4));
      k     = (kind == KAbortLoad) ? int'($urandom_range(0, 15))
            : (kind == KAbortWait) ? int'($urandom_range(0, 21)) - 1 : 0;
      delay = int'($urandom_range(1, HashWait + 3));
      run_attempt(kind, k, delay, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_auth_ctrl.md
SHA_AUTH_CTRL -- requirements
Module: sha_auth_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL provide parameter HASH_WAIT, default 80: maximum cycles to wait for sha_digest_valid after init.
REQ-003 The block SHALL provide parameter MAX_FAIL, default 3, legal range 1..15: consecutive failures before lockout.
REQ-004 The block SHALL have these ports:
  clk  in  1  clock, rising edge active
  reset  in  1  async active-high reset
  start  in  1  request one authentication attempt
  abort  in  1  cancel the current attempt
  in_valid  in  1  host word valid
  in_data  in  32  host word (8 block words, then 8 digest words, index 0 first)
  in_ready  out  1  controller accepts a word
  sha_rst_n  out  1  drives the sha256 wrapper reset_n
  sha_cs  out  1  init pulse to the wrapper
  sha_we  out  1  wrapper write enable
  sha_wc  out  1  1 = block register, 0 = digest register
  sha_addr  out  3  wrapper word address
  sha_wdata  out  32  wrapper write data
  sha_digest_valid  in  1  wrapper match flag
  busy  out  1  high in every state except IDLE and LOCK
  auth_pass  out  1  one-cycle pass pulse
  auth_fail  out  1  one-cycle fail pulse
  locked  out  1  lockout active
  fail_count  out  4  consecutive-failure count

Function
REQ-005 The block SHALL implement a state machine with states IDLE, CLR, LOAD_BLK, LOAD_DIG, HASH, WAIT, PASS, FAIL and LOCK.
REQ-006 In IDLE, a start=1 with locked=0 SHALL move the block to CLR; start SHALL be ignored in every other state.
REQ-007 CLR SHALL last exactly one cycle with sha_rst_n=0, which clears the sticky wrapper flag; sha_rst_n SHALL be 1 in all other states.
REQ-008 In LOAD_BLK and LOAD_DIG, in_ready SHALL be 1; in_ready SHALL be 0 in all other states.
REQ-009 The outputs sha_we, sha_addr and sha_wdata SHALL follow these rules:
  - sha_we = in_valid & in_ready, combinational;
  - sha_addr = word index;
  - sha_wdata = in_data;
  - sha_wc = 1 in LOAD_BLK, 0 in LOAD_DIG.
REQ-010 The word index (3 bits) SHALL increment on each accepted word and SHALL hold on in_valid=0.
REQ-011 When word 7 is accepted, the index SHALL wrap to 0 and the state SHALL advance: LOAD_BLK to LOAD_DIG, LOAD_DIG to HASH.
REQ-012 HASH SHALL assert sha_cs for exactly one cycle, then go to WAIT with the wait counter at 0.
REQ-013 In WAIT, sha_digest_valid=1 SHALL go to PASS.
REQ-014 In WAIT, when sha_digest_valid=0, the counter SHALL increment, and the block SHALL go to FAIL in the cycle the counter equals HASH_WAIT-1.
REQ-015 If sha_digest_valid=1 in the same cycle as the timeout, PASS SHALL win.
REQ-016 PASS SHALL pulse auth_pass for one cycle, clear fail_count and return to IDLE.
REQ-017 FAIL SHALL pulse auth_fail for one cycle and increment fail_count (saturating at 15).
REQ-018 From FAIL, the block SHALL go to LOCK if the new count is at least MAX_FAIL, otherwise to IDLE.
REQ-019 abort in CLR, LOAD_BLK or LOAD_DIG SHALL return the block to IDLE next cycle with no pulse and fail_count unchanged.
REQ-020 abort in HASH or WAIT SHALL go to FAIL, counting as a failure.
REQ-021 If abort and a word acceptance occur together, abort SHALL win and the word SHALL still be written.
REQ-022 LOCK SHALL hold locked=1 and busy=0, and SHALL be left only by reset.

Reset
REQ-023 Asserting reset SHALL immediately force the following values:
  - state IDLE;
  - sha_rst_n=0;
  - sha_cs, sha_we, sha_wc, sha_addr, sha_wdata all 0;
  - in_ready, busy, auth_pass, auth_fail, locked all 0;
  - fail_count=0;
  - word index and wait counter 0.
REQ-024 Reset asserted mid-attempt or in LOCK SHALL discard the attempt and clear the lockout.
REQ-025 After reset deasserts, sha_rst_n SHALL rise at the first clk edge.

Verification
REQ-026 Pass case: start, 16 words with matching digest, model asserts sha_digest_valid 64 cycles after sha_cs -> auth_pass pulse, fail_count=0, busy=0.
REQ-027 Mismatch case: no sha_digest_valid -> auth_fail exactly HASH_WAIT cycles after the cycle following sha_cs, fail_count=1.
REQ-028 Lockout: 3 consecutive fails -> locked=1, and a further start gives busy=0 and no sha_cs.
REQ-029 Lockout recovery: after lockout, reset then a pass -> locked=0 and auth_pass pulse.
REQ-030 Backpressure and abort: in_valid toggled every other cycle, then abort at block word 5 -> exactly 5 sha_we strobes (addr 0..4, sha_wc=1), then IDLE, no pulse, fail_count unchanged.
REQ-031 Stale flag: sha_digest_valid held high from a prior pass, new attempt -> sha_rst_n low for one cycle in CLR.
REQ-032 Boundary: sha_digest_valid and timeout in the same cycle -> auth_pass.
